// File: rtl/linear_layer_start_fifo_shiftreg.sv
// Token storage for the start FIFO: a shift register that takes a new token at
// index 0 and is read at an arbitrary index.
module linear_layer_start_fifo_shiftreg #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    // Contents are never reset; the parent only reads indices below its count.
    logic [DATA_WIDTH-1:0] srl_sig [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                srl_sig[i] <= srl_sig[i-1];
            end
            srl_sig[0] <= din;
        end
    end

    assign dout = srl_sig[addr];

endmodule

// File: rtl/linear_layer_start_fifo_srl.sv
// Start-token FIFO between the producer and the PE process: occupancy count,
// registered full/empty flags and read addressing around an SRL store.
module linear_layer_start_fifo_srl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n
);

    if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_depth_check
        $error("linear_layer_start_fifo_srl: DEPTH must be in 1..2**ADDR_WIDTH");
    end

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE        = (ADDR_WIDTH + 1)'(1);

    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  full_n_r;
    logic                  empty_n_r;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] addr;

    // Qualifying with the registered flags drops writes when full and reads when empty.
    assign push = if_write & if_write_ce & full_n_r;
    assign pop  = if_read  & if_read_ce  & empty_n_r;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + ONE;
        end else if (pop && !push) begin
            count_next = count - ONE;
        end
    end

    // Oldest token sits at count-1 because every push shifts the whole array.
    always_comb begin
        addr = '0;
        if (count != '0) begin
            addr = ADDR_WIDTH'(count - ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            full_n_r  <= 1'b1;
            empty_n_r <= 1'b0;
        end else begin
            count     <= count_next;
            full_n_r  <= (count_next != FULL_COUNT);
            empty_n_r <= (count_next != '0);
        end
    end

    assign if_full_n  = full_n_r;
    assign if_empty_n = empty_n_r;

    linear_layer_start_fifo_shiftreg #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH)
    ) u_shiftreg (
        .clk (clk),
        .we  (push),
        .addr(addr),
        .din (if_din),
        .dout(if_dout)
    );

endmodule

// File: tb/tb_linear_layer_start_fifo_srl.sv
// Bench for the start-token FIFO: a DEPTH=4 and a DEPTH=1 instance, each
// compared against a queue-based reference model.
module tb_linear_layer_start_fifo_srl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    // DEPTH=4 instance
    logic       w_ce, w, r_ce, r;
    logic [7:0] din, dout;
    logic       full_n, empty_n;
    // DEPTH=1 instance
    logic       w1, r1;
    logic       w_ce1, r_ce1;
    logic [7:0] din1, dout1;
    logic       full_n1, empty_n1;

    int checks = 0;
    int fails  = 0;

    logic [7:0] q  [$];
    logic [7:0] q1 [$];

    linear_layer_start_fifo_srl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .if_write_ce(w_ce), .if_write(w), .if_din(din), .if_full_n(full_n),
        .if_read_ce(r_ce), .if_read(r), .if_dout(dout), .if_empty_n(empty_n)
    );

    linear_layer_start_fifo_srl #(.DATA_WIDTH(8), .ADDR_WIDTH(1), .DEPTH(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .if_write_ce(w_ce1), .if_write(w1), .if_din(din1), .if_full_n(full_n1),
        .if_read_ce(r_ce1), .if_read(r1), .if_dout(dout1), .if_empty_n(empty_n1)
    );

    // Advance one clock; the model applies the FIFO rules to the inputs seen at the edge.
    task automatic tick();
        bit p, ps;
        logic [7:0] v;
        @(posedge clk);
        if (reset) begin
            q.delete();
            q1.delete();
        end else begin
            p  = w && w_ce && (q.size() < 4);
            ps = r && r_ce && (q.size() > 0);
            if (ps) v = q.pop_front();
            if (p) q.push_back(din);
            p  = w1 && w_ce1 && (q1.size() < 1);
            ps = r1 && r_ce1 && (q1.size() > 0);
            if (ps) v = q1.pop_front();
            if (p) q1.push_back(din1);
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; w = 1'b1; din = 8'hEE; r = 1'b1;
        tick(); tick();
        checks++;
        if (empty_n !== 1'b0 || full_n !== 1'b1) begin
            fails++;
            $display("FAIL reset_flags: empty_n=%b full_n=%b, required empty_n=0 full_n=1", empty_n, full_n);
        end
        reset = 1'b0; w = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (empty_n !== 1'b0 || full_n !== 1'b1) begin
                fails++;
                $display("FAIL reset_read_empty[%0d]: empty_n=%b full_n=%b, required 0/1", i, empty_n, full_n);
            end
        end
        r = 1'b0;
    endtask

    task automatic test_fill_drain();
        logic [7:0] vals [4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            w = 1'b1; din = vals[i];
            tick();
            checks++;
            if (empty_n !== 1'b1 || full_n !== (i < 3)) begin
                fails++;
                $display("FAIL fill[%0d]: empty_n=%b full_n=%b, required 1/%b", i, empty_n, full_n, (i < 3));
            end
        end
        din = 8'h55;
        tick();
        w = 1'b0;
        checks++;
        if (full_n !== 1'b0 || q.size() != 4) begin
            fails++;
            $display("FAIL overflow_drop: full_n=%b, required 0", full_n);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dout !== vals[i]) begin
                fails++;
                $display("FAIL drain_data[%0d]: dout=%h, required %h", i, dout, vals[i]);
            end
            r = 1'b1;
            tick();
            checks++;
            if (empty_n !== (i < 3) || full_n !== 1'b1) begin
                fails++;
                $display("FAIL drain_flags[%0d]: empty_n=%b full_n=%b, required %b/1", i, empty_n, full_n, (i < 3));
            end
        end
        r = 1'b0;
    endtask

    task automatic test_simultaneous();
        w = 1'b1; din = 8'hA0; tick();
        din = 8'hA1; tick();
        din = 8'hA2; r = 1'b1;
        checks++;
        if (dout !== 8'hA0) begin
            fails++;
            $display("FAIL simul_read: dout=%h, required a0", dout);
        end
        tick();
        w = 1'b0;
        checks++;
        if (empty_n !== 1'b1 || full_n !== 1'b1 || q.size() != 2) begin
            fails++;
            $display("FAIL simul_count: empty_n=%b full_n=%b, required 1/1", empty_n, full_n);
        end
        checks++;
        if (dout !== 8'hA1) begin
            fails++;
            $display("FAIL simul_next1: dout=%h, required a1", dout);
        end
        tick();
        checks++;
        if (dout !== 8'hA2 || empty_n !== 1'b1) begin
            fails++;
            $display("FAIL simul_next2: dout=%h empty_n=%b, required a2/1", dout, empty_n);
        end
        tick();
        r = 1'b0;
        checks++;
        if (empty_n !== 1'b0) begin
            fails++;
            $display("FAIL simul_empty: empty_n=%b, required 0", empty_n);
        end
    endtask

    task automatic test_ce_gating();
        w = 1'b1; din = 8'h5A; tick();
        din = 8'h5B; tick();
        w_ce = 1'b0; r_ce = 1'b0; r = 1'b1; din = 8'h66;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (empty_n !== 1'b1 || full_n !== 1'b1 || dout !== 8'h5A) begin
                fails++;
                $display("FAIL ce_gate[%0d]: empty_n=%b full_n=%b dout=%h, required 1/1/5a", i, empty_n, full_n, dout);
            end
        end
        w = 1'b0; w_ce = 1'b1; r_ce = 1'b1;
        tick();
        checks++;
        if (dout !== 8'h5B || empty_n !== 1'b1) begin
            fails++;
            $display("FAIL ce_after1: dout=%h empty_n=%b, required 5b/1", dout, empty_n);
        end
        tick();
        r = 1'b0;
        checks++;
        if (empty_n !== 1'b0) begin
            fails++;
            $display("FAIL ce_after2: empty_n=%b, required 0", empty_n);
        end
    endtask

    task automatic test_mid_reset();
        w = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = 8'hC0 + 8'(i);
            tick();
        end
        reset = 1'b1; din = 8'h99;
        tick();
        checks++;
        if (empty_n !== 1'b0 || full_n !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset: empty_n=%b full_n=%b, required 0/1", empty_n, full_n);
        end
        reset = 1'b0; din = 8'h7E;
        tick();
        w = 1'b0;
        checks++;
        if (empty_n !== 1'b1 || dout !== 8'h7E) begin
            fails++;
            $display("FAIL mid_reset_write: empty_n=%b dout=%h, required 1/7e", empty_n, dout);
        end
        r = 1'b1;
        tick();
        r = 1'b0;
        checks++;
        if (empty_n !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_read: empty_n=%b, required 0", empty_n);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            w    = 1'($urandom_range(0, 1));
            r    = 1'($urandom_range(0, 1));
            w_ce = ($urandom_range(0, 7) != 0);
            r_ce = ($urandom_range(0, 7) != 0);
            din  = 8'($urandom);
            if (q.size() > 0) begin
                checks++;
                if (dout !== q[0]) begin
                    fails++;
                    $display("FAIL rand_data[%0d]: dout=%h, required %h", i, dout, q[0]);
                end
            end
            tick();
            checks++;
            if (empty_n !== (q.size() != 0) || full_n !== (q.size() != 4)) begin
                fails++;
                $display("FAIL rand_flags[%0d]: empty_n=%b full_n=%b, required %b/%b",
                         i, empty_n, full_n, (q.size() != 0), (q.size() != 4));
            end
        end
        w = 1'b0; r = 1'b0; w_ce = 1'b1; r_ce = 1'b1;
        for (int i = 0; i < 5; i++) begin
            r = 1'b1;
            tick();
        end
        r = 1'b0;
    endtask

    task automatic test_depth1();
        int sent = 0;
        int recv = 0;
        int dut_pops = 0;
        w1 = 1'b1; r1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            din1 = 8'h30 + 8'(sent);
            if (empty_n1 === 1'b1) begin
                dut_pops++;
                checks++;
                if (dout1 !== 8'h30 + 8'(recv)) begin
                    fails++;
                    $display("FAIL d1_data[%0d]: dout=%h, required %h", i, dout1, 8'h30 + 8'(recv));
                end
            end
            if (q1.size() > 0) recv++;
            else sent++;
            tick();
            checks++;
            if (empty_n1 !== (q1.size() != 0) || full_n1 !== (q1.size() == 0)) begin
                fails++;
                $display("FAIL d1_flags[%0d]: empty_n=%b full_n=%b, required %b/%b",
                         i, empty_n1, full_n1, (q1.size() != 0), (q1.size() == 0));
            end
        end
        w1 = 1'b0; r1 = 1'b0;
        checks++;
        if (dut_pops != 10) begin
            fails++;
            $display("FAIL d1_throughput: tokens=%0d, required 10", dut_pops);
        end
    endtask

    initial begin
        reset = 1'b1;
        w = 1'b0; r = 1'b0; w_ce = 1'b1; r_ce = 1'b1; din = '0;
        w1 = 1'b0; r1 = 1'b0; w_ce1 = 1'b1; r_ce1 = 1'b1; din1 = '0;
        test_reset();
        test_fill_drain();
        test_simultaneous();
        test_ce_gating();
        test_mid_reset();
        test_random();
        test_depth1();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
